// File: rtl/servisia_mem_bridge_pkg.sv
// Shared constants for the servisia memory bridge: FSM encodings and byte-lane sizing.
package servisia_mem_bridge_pkg;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned LANE_W = $clog2(NBYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

endpackage

// File: rtl/servisia_mem_bridge.sv
// Wishbone-classic slave that serialises 32-bit accesses into four byte strobes
// for servisia_mem and gathers read bytes into one registered word.
module servisia_mem_bridge
    import servisia_mem_bridge_pkg::*;
#(
    parameter int unsigned MEM_AW = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    output logic [31:0]       wb_rdt_o,
    output logic              wb_ack_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    logic [1:0]        r_state;
    logic [LANE_W-1:0] r_cnt;
    logic [MEM_AW-3:0] r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic [23:0]       r_gather;

    logic [LANE_W-1:0] w_cnt_nxt;
    logic              w_last;
    logic              w_unused_adr;

    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign w_last       = (r_cnt == LANE_W'(NBYTES - 1));
    assign w_unused_adr = ^{wb_adr_i[31:MEM_AW], wb_adr_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_gather    <= '0;
            wb_rdt_o    <= '0;
            wb_ack_o    <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wb_cyc_i) begin
                        r_adr       <= wb_adr_i[MEM_AW-1:2];
                        r_dat       <= wb_dat_i;
                        r_sel       <= wb_sel_i;
                        r_we        <= wb_we_i;
                        r_cnt       <= '0;
                        mem_addr_o  <= {wb_adr_i[MEM_AW-1:2], LANE_W'(0)};
                        mem_wdata_o <= wb_dat_i[7:0];
                        mem_read_o  <= ~wb_we_i;
                        mem_write_o <= wb_we_i & wb_sel_i[0];
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // rdata trails its strobe by one cycle, so this cycle carries lane cnt-1
                    for (int i = 0; i < 3; i++) begin
                        if (!r_we && r_cnt == LANE_W'(i + 1)) begin
                            r_gather[8*i +: 8] <= mem_rdata_i;
                        end
                    end
                    if (w_last) begin
                        mem_read_o  <= 1'b0;
                        mem_write_o <= 1'b0;
                        wb_ack_o    <= r_we;
                        r_state     <= r_we ? ST_ACK : ST_DRAIN;
                    end else begin
                        r_cnt       <= w_cnt_nxt;
                        mem_addr_o  <= {r_adr, w_cnt_nxt};
                        mem_wdata_o <= r_dat[8*w_cnt_nxt +: 8];
                        mem_read_o  <= ~r_we;
                        mem_write_o <= r_we & r_sel[w_cnt_nxt];
                    end
                end
                ST_DRAIN: begin
                    wb_rdt_o <= {mem_rdata_i, r_gather};
                    wb_ack_o <= 1'b1;
                    r_state  <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servisia_mem_bridge.sv
// Directed bench for servisia_mem_bridge with a byte-wide registered memory model.
module tb_servisia_mem_bridge;
    import servisia_mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_rdt_o;
    logic        wb_ack_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [20:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  mem [256];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_ack = 1'b0;

    int          log_cyc[$];
    logic [20:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic        log_we[$];

    servisia_mem_bridge #(.MEM_AW(21)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_rdt_o   (wb_rdt_o),
        .wb_ack_o   (wb_ack_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // servisia_mem stand-in: registered read data, one cycle behind the strobe
    always @(posedge clk) begin
        if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
        if (mem_read_o) mem_rdata <= mem[mem_addr_o[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("rw_excl", 32'(mem_read_o & mem_write_o), 32'd0);
            check_eq("ack_width", 32'(prev_ack & wb_ack_o), 32'd0);
            if (dut.r_state == ST_ACCESS) check_eq("addr_cnt", 32'(mem_addr_o[1:0]), 32'(dut.r_cnt));
        end
        prev_ack = wb_ack_o;
    end

    a_rw_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read_o && mem_write_o));
    a_ack_w:   assert property (@(posedge clk) disable iff (rst) wb_ack_o |=> !wb_ack_o);

    task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        wb_we  = we;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_cyc = 1'b1;
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    // Cycle c counts negedges after the request was driven; bounded to 10 cycles.
    task automatic watch(input int drop_at, input bit keep, output int ack_cyc,
                         output logic [31:0] rdt, output int n_ack);
        ack_cyc = -1;
        rdt     = '0;
        n_ack   = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == drop_at) wb_cyc = 1'b0;
            if (mem_read_o || mem_write_o) begin
                log_cyc.push_back(c);
                log_addr.push_back(mem_addr_o);
                log_data.push_back(mem_wdata_o);
                log_we.push_back(mem_write_o);
            end
            if (wb_ack_o) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = c;
                    rdt     = wb_rdt_o;
                end
                if (keep) break;
                wb_cyc = 1'b0;
            end
        end
    endtask

    int          ack_cyc;
    int          n_ack;
    logic [31:0] rdt;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        mem[8'h40] = 8'h11;
        mem[8'h41] = 8'h22;
        mem[8'h42] = 8'h33;
        mem[8'h43] = 8'h44;

        #12;
        check_eq("rst_read", 32'(mem_read_o), 32'd0);
        check_eq("rst_write", 32'(mem_write_o), 32'd0);
        check_eq("rst_addr", 32'(mem_addr_o), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata_o), 32'd0);
        check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
        check_eq("rst_rdt", wb_rdt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain read
        @(negedge clk);
        start(1'b0, 32'h0010_0040, 32'h0, 4'h0);
        watch(0, 1'b0, ack_cyc, rdt, n_ack);
        check_eq("rd_ack_cyc", ack_cyc, 32'd6);
        check_eq("rd_rdt", rdt, 32'h4433_2211);
        check_eq("rd_nstrobe", log_cyc.size(), 32'd4);
        for (int i = 0; i < log_cyc.size(); i++) begin
            check_eq("rd_addr", 32'(log_addr[i]), 32'h0010_0040 + 32'(i));
            check_eq("rd_cyc", log_cyc[i], 32'(i + 1));
            check_eq("rd_we", 32'(log_we[i]), 32'd0);
        end

        // Sparse write: only lanes 0 and 2 strobed, schedule not shortened
        @(negedge clk);
        start(1'b1, 32'h0010_0008, 32'hA1B2_C3D4, 4'b0101);
        watch(0, 1'b0, ack_cyc, rdt, n_ack);
        check_eq("wr_ack_cyc", ack_cyc, 32'd5);
        check_eq("wr_rdt_held", rdt, 32'h4433_2211);
        check_eq("wr_nstrobe", log_cyc.size(), 32'd2);
        if (log_cyc.size() == 2) begin
            check_eq("wr0_addr", 32'(log_addr[0]), 32'h0010_0008);
            check_eq("wr0_data", 32'(log_data[0]), 32'h0000_00D4);
            check_eq("wr0_cyc", log_cyc[0], 32'd1);
            check_eq("wr0_we", 32'(log_we[0]), 32'd1);
            check_eq("wr1_addr", 32'(log_addr[1]), 32'h0010_000A);
            check_eq("wr1_data", 32'(log_data[1]), 32'h0000_00B2);
            check_eq("wr1_cyc", log_cyc[1], 32'd3);
            check_eq("wr1_we", 32'(log_we[1]), 32'd1);
        end
        check_eq("wr_mem09", 32'(mem[8'h09]), 32'h0000_0009);
        check_eq("wr_mem0b", 32'(mem[8'h0B]), 32'h0000_000B);

        // Back-to-back write then read with cyc held high
        @(negedge clk);
        start(1'b1, 32'h0010_0020, 32'hCAFE_F00D, 4'hF);
        watch(0, 1'b1, ack_cyc, rdt, n_ack);
        check_eq("b2b_wr_ack", ack_cyc, 32'd5);
        check_eq("b2b_cyc_held", 32'(wb_cyc), 32'd1);
        start(1'b0, 32'h0010_0020, 32'h0, 4'h0);
        watch(0, 1'b0, ack_cyc, rdt, n_ack);
        check_eq("b2b_rd_ack", ack_cyc, 32'd7);
        check_eq("b2b_rd_rdt", rdt, 32'hCAFE_F00D);
        check_eq("b2b_first_cyc", log_cyc.size() > 0 ? log_cyc[0] : -1, 32'd2);

        // cyc dropped mid-read: access still completes with a single ack
        @(negedge clk);
        start(1'b0, 32'h0010_0040, 32'h0, 4'h0);
        watch(2, 1'b0, ack_cyc, rdt, n_ack);
        check_eq("drop_ack_cyc", ack_cyc, 32'd6);
        check_eq("drop_n_ack", n_ack, 32'd1);
        check_eq("drop_nstrobe", log_cyc.size(), 32'd4);
        check_eq("drop_rdt", rdt, 32'h4433_2211);

        // Reset during byte 2 of a write
        @(negedge clk);
        start(1'b1, 32'h0010_0010, 32'h1122_3344, 4'hF);
        repeat (3) @(negedge clk);
        check_eq("mid_pre_write", 32'(mem_write_o), 32'd1);
        check_eq("mid_pre_addr", 32'(mem_addr_o), 32'h0010_0012);
        #1;
        rst    = 1'b1;
        wb_cyc = 1'b0;
        #1;
        check_eq("mid_write", 32'(mem_write_o), 32'd0);
        check_eq("mid_read", 32'(mem_read_o), 32'd0);
        check_eq("mid_ack", 32'(wb_ack_o), 32'd0);
        check_eq("mid_rdt", wb_rdt_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        repeat (10) begin
            @(negedge clk);
            if (wb_ack_o) n_ack++;
        end
        check_eq("mid_no_ack", n_ack, 32'd0);
        check_eq("mid_mem11", 32'(mem[8'h11]), 32'h0000_0033);
        check_eq("mid_mem12", 32'(mem[8'h12]), 32'h0000_0012);

        // Normal access after the abandoned write
        @(negedge clk);
        start(1'b0, 32'h0010_0010, 32'h0, 4'h0);
        watch(0, 1'b0, ack_cyc, rdt, n_ack);
        check_eq("post_ack_cyc", ack_cyc, 32'd6);
        check_eq("post_rdt", rdt, 32'h1312_3344);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
